// File: rtl/program_counter_pkg.sv
// Shared CPU constants: address width, reset vector and instruction step size.
package program_counter_pkg;

  localparam int          PC_WIDTH      = 32;
  localparam logic [31:0] PC_RESET_ADDR = 32'h0000_0000;
  localparam int          PC_STEP       = 4;

endpackage

// File: rtl/program_counter_if.sv
// Program counter bus: next-PC input plus the registered PC and its derived status.
interface program_counter_if
  import program_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
);

  logic [WIDTH-1:0] Address;
  logic [WIDTH-1:0] Out_Addr;
  logic [WIDTH-1:0] Pc_plus4;
  logic             Misaligned;
  logic             Valid;

  modport master (
    output Address,
    input  Out_Addr,
    input  Pc_plus4,
    input  Misaligned,
    input  Valid
  );

  modport slave (
    input  Address,
    output Out_Addr,
    output Pc_plus4,
    output Misaligned,
    output Valid
  );

endinterface

// File: rtl/program_counter.sv
// Registered program counter with a next-sequential address and an alignment flag.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int               WIDTH      = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR),
  parameter int               STEP       = PC_STEP
) (
  input  logic                    clk,
  input  logic                    reset,
  program_counter_if.slave        bus
);

  logic [WIDTH-1:0] pc_reg;
  logic             valid_reg;

  // Reset has priority over any Address presented on the same edge.
  always_ff @(posedge clk) begin
    if (reset == 1'b1) begin
      pc_reg    <= RESET_ADDR;
      valid_reg <= 1'b0;
    end else begin
      pc_reg    <= bus.Address;
      valid_reg <= 1'b1;
    end
  end

  assign bus.Out_Addr   = pc_reg;
  assign bus.Pc_plus4   = pc_reg + WIDTH'(STEP);
  assign bus.Misaligned = |pc_reg[1:0];
  assign bus.Valid      = valid_reg;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench: vector table, hand-written hold/reset sequences and a random stream.
module tb_program_counter;

  typedef struct packed {
    logic [31:0] out_addr;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        valid;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic [31:0] addr;
    exp_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  program_counter_if bus ();

  program_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic apply(input string name, input logic r, input logic [31:0] a, input exp_t e);
    exp_t got;
    reset       = r;
    bus.Address = a;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({name, ".out_addr"},   bus.Out_Addr,          got.out_addr);
    chk({name, ".pc_plus4"},   bus.Pc_plus4,          got.pc_plus4);
    chk({name, ".misaligned"}, 32'(bus.Misaligned),   32'(got.misaligned));
    chk({name, ".valid"},      32'(bus.Valid),        32'(got.valid));
    $display("txn %-8s rst=%b addr=%h -> out=%h p4=%h mis=%b v=%b",
             name, r, a, bus.Out_Addr, bus.Pc_plus4, bus.Misaligned, bus.Valid);
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] a;
    int          mism;

    vecs[0]  = '{1'b1, 32'h0000_0010, '{32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0}};
    vecs[1]  = '{1'b1, 32'h0000_0020, '{32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0}};
    vecs[2]  = '{1'b0, 32'h0000_0000, '{32'h0000_0000, 32'h0000_0004, 1'b0, 1'b1}};
    vecs[3]  = '{1'b0, 32'h0000_0002, '{32'h0000_0002, 32'h0000_0006, 1'b1, 1'b1}};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFC, '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b1}};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF, '{32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 1'b1}};
    vecs[6]  = '{1'b0, 32'h0000_0001, '{32'h0000_0001, 32'h0000_0005, 1'b1, 1'b1}};
    vecs[7]  = '{1'b0, 32'h1234_5678, '{32'h1234_5678, 32'h1234_567C, 1'b0, 1'b1}};
    vecs[8]  = '{1'b1, 32'h0000_0040, '{32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0}};
    vecs[9]  = '{1'b0, 32'h0000_0040, '{32'h0000_0040, 32'h0000_0044, 1'b0, 1'b1}};
    vecs[10] = '{1'b0, 32'h8000_0003, '{32'h8000_0003, 32'h8000_0007, 1'b1, 1'b1}};
    vecs[11] = '{1'b0, 32'h0000_0008, '{32'h0000_0008, 32'h0000_000C, 1'b0, 1'b1}};

    reset       = 1'b1;
    bus.Address = '0;
    #1;

    for (int i = 0; i < 12; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].addr, vecs[i].exp);
    end

    // Address changes mid-cycle must not disturb the registered PC.
    bus.Address = 32'h0000_000C;
    #3;
    chk("hold_mid_cycle", bus.Out_Addr, 32'h0000_0008);
    apply("hold_edge", 1'b0, 32'h0000_000C, '{32'h0000_000C, 32'h0000_0010, 1'b0, 1'b1});

    // Reset coinciding with a new Address wins, then the first free edge loads normally.
    apply("rst_win", 1'b1, 32'h0000_0040, '{32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0});
    apply("rst_rel", 1'b0, 32'h0000_0040, '{32'h0000_0040, 32'h0000_0044, 1'b0, 1'b1});

    // Random stream: Out_Addr(n) must equal Address(n-1) every cycle.
    mism = n_fail;
    for (int i = 0; i < 1000; i++) begin
      exp_t got;
      a           = $urandom;
      reset       = 1'b0;
      bus.Address = a;
      sb.push_back('{a, a + 32'd4, |a[1:0], 1'b1});
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("rand.out_addr", bus.Out_Addr, got.out_addr);
      chk("rand.pc_plus4", bus.Pc_plus4, got.pc_plus4);
      chk("rand.misaligned", 32'(bus.Misaligned), 32'(got.misaligned));
      chk("rand.valid", 32'(bus.Valid), 32'(got.valid));
    end
    $display("txn random  1000 cycles, %0d failing comparisons", n_fail - mism);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter WIDTH, default 32: address width in bits.
REQ-002 Parameter RESET_ADDR, default 32'h0000_0000: value loaded into the PC on reset.
REQ-003 Parameter STEP, default 4: instruction size in bytes, used for Pc_plus4.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset; only logic 1 counts as asserted.
REQ-006 Address  input  WIDTH  next-PC value to load.
REQ-007 Out_Addr  output  WIDTH  current PC (registered).
REQ-008 Pc_plus4  output  WIDTH  Out_Addr + STEP (combinational).
REQ-009 Misaligned  output  1  high when Out_Addr[1:0] != 2'b00.
REQ-010 Valid  output  1  high once the PC has taken at least one load since reset.

Function
REQ-011 On each rising clk edge with reset low, Out_Addr SHALL take the value of Address sampled at that edge; latency is exactly 1 cycle.
REQ-012 Between edges, Out_Addr SHALL hold its value regardless of Address changes.
REQ-013 Pc_plus4 SHALL equal (Out_Addr + STEP) mod 2^WIDTH, so 32'hFFFF_FFFC yields 32'h0000_0000.
REQ-014 Misaligned SHALL be derived combinationally from Out_Addr and carry no extra latency.
REQ-015 Address SHALL be loaded unmodified; misaligned values are not corrected or truncated.
REQ-016 Valid SHALL go high on the first rising edge with reset low and stay high until reset.
REQ-017 When reset and an Address change coincide at an edge, reset SHALL win.

Reset
REQ-018 While reset is high at a rising edge, Out_Addr SHALL become RESET_ADDR and Valid SHALL become 0.
REQ-019 After that reset edge, Pc_plus4 SHALL read RESET_ADDR + STEP and Misaligned SHALL read 0 with the default RESET_ADDR.
REQ-020 Asserting reset mid-operation SHALL discard the pending Address and take effect at the next edge only, with no asynchronous path.
REQ-021 The first edge after reset deasserts SHALL load Address normally.

Structure
REQ-022 The WIDTH default, the RESET_ADDR default and the STEP constant belong in the shared CPU package.
REQ-023 The module is a single flat block with no sub-modules: one register process and combinational output assigns.

Verification
REQ-024 Apply a 10 ns clock with reset=1 for 2 edges -> Out_Addr=0, Valid=0, Pc_plus4=4, Misaligned=0.
REQ-025 With reset=0 and Address=0 until 100 ns, then Address=2 -> Out_Addr=0 before the first edge after 100 ns and 2 after it; Misaligned=1 from that edge; Pc_plus4=6.
REQ-026 Set Address=32'hFFFF_FFFC and clock once -> Out_Addr=32'hFFFF_FFFC and Pc_plus4=32'h0000_0000.
REQ-027 Change Address mid-cycle from 8 to 12 -> Out_Addr stays at its previous value until the edge, then reads 12.
REQ-028 Assert reset in the same cycle as Address=32'h40 -> Out_Addr=RESET_ADDR and Valid=0; after reset deasserts, the next edge gives Out_Addr=32'h40 and Valid=1.
REQ-029 Drive a random Address stream for 1000 cycles -> a scoreboard confirms Out_Addr(n)=Address(n-1) every cycle.
